// File: rtl/dvp_frame_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dvp_frame_tx : Wishbone-programmed DVP transmitter streaming a word buffer |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module dvp_frame_tx #(
  parameter int BUF_AW  = 8,
  parameter int LINES_W = 10,
  parameter int BLANK_W = 12
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic [9:0]  WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic        WBs_STB_i,
  input  logic        WBs_WE_i,
  input  logic [3:0]  WBs_BYTE_STB_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  output logic        PCLKO,
  output logic        VSYNCO,
  output logic        HREFO,
  output logic [7:0]  CAM_DAT_o,
  output logic        Frame_Done_o
);

  localparam int LW_W  = BUF_AW + 1;
  localparam int CNT_W = (BLANK_W > BUF_AW + 3) ? BLANK_W : BUF_AW + 3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_VFP  = 3'd2;
  localparam logic [2:0] S_LINE = 3'd3;
  localparam logic [2:0] S_HBL  = 3'd4;
  localparam logic [2:0] S_VBP  = 3'd5;
  localparam logic [2:0] S_VEND = 3'd6;

  logic [31:0]        mem_q [0:(1<<BUF_AW)-1];
  logic [31:0]        host_rd_q, tx_rd_q;

  logic               ack_q;
  logic               en_q, en_d, cont_q, cont_d, done_q, done_d;
  logic [LW_W-1:0]    lw_q, lw_d, lws_q, lws_d;
  logic [LINES_W-1:0] nl_q, nl_d, nls_q, nls_d, line_q, line_d;
  logic [BLANK_W-1:0] hb_q, hb_d, hbs_q, hbs_d, vb_q, vb_d, vbs_q, vbs_d;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUF_AW-1:0]  ptr_q, ptr_d;
  logic [31:0]        sh_q, sh_d;
  logic [1:0]         bidx_q, bidx_d;
  logic               phase_q, phase_d, vs_q, vs_d, hr_q, hr_d;
  logic [7:0]         dat_q, dat_d;

  logic               w_wr, w_regsel, w_start, w_tick, w_ld, w_shadow;
  logic [2:0]         w_ra;
  logic [LW_W-1:0]    w_lw1;
  logic [LINES_W-1:0] w_nl1;
  logic [BLANK_W-1:0] w_hb1, w_vb1;
  logic [31:0]        w_status;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign w_wr     = ack_q & WBs_CYC_i & WBs_STB_i & WBs_WE_i;
  assign w_regsel = ~WBs_ADR_i[9] & (WBs_ADR_i[8:3] == 6'd0);
  assign w_ra     = WBs_ADR_i[2:0];
  assign w_start  = w_wr & w_regsel & (w_ra == 3'd0) & WBs_BYTE_STB_i[0] & WBs_DAT_i[2];
  assign w_tick   = phase_q & en_q;

  // Zero-valued timing fields behave as 1.
  assign w_lw1 = (lw_q == '0) ? LW_W'(1)    : lw_q;
  assign w_nl1 = (nl_q == '0) ? LINES_W'(1) : nl_q;
  assign w_hb1 = (hb_q == '0) ? BLANK_W'(1) : hb_q;
  assign w_vb1 = (vb_q == '0) ? BLANK_W'(1) : vb_q;

  always_comb begin
    w_status = 32'd0;
    w_status[0] = (state_q != S_IDLE);
    w_status[1] = done_q;
    w_status[16 +: LINES_W] = line_q;
  end

  always_comb begin
    WBs_DAT_o = 32'd0;
    if (ack_q) begin
      if (WBs_ADR_i[9]) begin
        WBs_DAT_o = host_rd_q;
      end else if (w_regsel) begin
        case (w_ra)
          3'd0:    WBs_DAT_o = {30'd0, cont_q, en_q};
          3'd1:    WBs_DAT_o = 32'(lw_q);
          3'd2:    WBs_DAT_o = 32'(nl_q);
          3'd3:    WBs_DAT_o = 32'(hb_q);
          3'd4:    WBs_DAT_o = 32'(vb_q);
          3'd5:    WBs_DAT_o = w_status;
          default: WBs_DAT_o = 32'd0;
        endcase
      end
    end
  end

  always_comb begin
    en_d = en_q;  cont_d = cont_q;  done_d = done_q;
    lw_d = lw_q;  nl_d = nl_q;  hb_d = hb_q;  vb_d = vb_q;
    lws_d = lws_q;  nls_d = nls_q;  hbs_d = hbs_q;  vbs_d = vbs_q;
    state_d = state_q;  cnt_d = cnt_q;  line_d = line_q;  ptr_d = ptr_q;
    sh_d = sh_q;  bidx_d = bidx_q;  vs_d = vs_q;  hr_d = hr_q;  dat_d = dat_q;
    phase_d = en_q & ~phase_q;
    w_ld = 1'b0;
    w_shadow = 1'b0;

    if (w_wr && w_regsel) begin
      case (w_ra)
        3'd0: if (WBs_BYTE_STB_i[0]) begin
          en_d   = WBs_DAT_i[0];
          cont_d = WBs_DAT_i[1];
        end
        3'd1: lw_d = LW_W'(f_merge(32'(lw_q), WBs_DAT_i, WBs_BYTE_STB_i));
        3'd2: nl_d = LINES_W'(f_merge(32'(nl_q), WBs_DAT_i, WBs_BYTE_STB_i));
        3'd3: hb_d = BLANK_W'(f_merge(32'(hb_q), WBs_DAT_i, WBs_BYTE_STB_i));
        3'd4: vb_d = BLANK_W'(f_merge(32'(vb_q), WBs_DAT_i, WBs_BYTE_STB_i));
        3'd5: if (WBs_BYTE_STB_i[0] && WBs_DAT_i[1]) done_d = 1'b0;
        default: ;
      endcase
    end

    // ARM holds the idle outputs until the next tick so VSYNCO rises on a PCLKO fall.
    if (w_start && en_d && state_q == S_IDLE) begin
      state_d  = S_ARM;
      w_shadow = 1'b1;
    end else if (!en_q) begin
      state_d = S_IDLE;
      vs_d = 1'b0;  hr_d = 1'b0;  dat_d = 8'd0;
    end else if (w_tick) begin
      case (state_q)
        S_ARM: begin
          state_d = S_VFP;
          cnt_d   = CNT_W'(vbs_q);
          vs_d    = 1'b1;
        end
        S_VFP, S_HBL: begin
          if (cnt_q == CNT_W'(1)) begin
            if (state_q == S_HBL) line_d = line_q + LINES_W'(1);
            state_d = S_LINE;
            cnt_d   = CNT_W'({lws_q, 2'b00});
            hr_d    = 1'b1;
            w_ld    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_LINE: begin
          if (cnt_q == CNT_W'(1)) begin
            hr_d  = 1'b0;
            dat_d = 8'd0;
            if (line_q == nls_q - LINES_W'(1)) begin
              state_d = S_VBP;
              cnt_d   = CNT_W'(vbs_q);
            end else begin
              state_d = S_HBL;
              cnt_d   = CNT_W'(hbs_q);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (bidx_q == 2'd0) begin
              w_ld = 1'b1;
            end else begin
              dat_d  = sh_q[31:24];
              sh_d   = {sh_q[23:0], 8'h00};
              bidx_d = bidx_q + 2'd1;
            end
          end
        end
        S_VBP: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_VEND;
            cnt_d   = CNT_W'(vbs_q);
            vs_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_VEND: begin
          if (cnt_q == CNT_W'(1)) begin
            done_d = 1'b1;
            if (cont_q) begin
              w_shadow = 1'b1;
              state_d  = S_VFP;
              cnt_d    = CNT_W'(w_vb1);
              vs_d     = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (w_shadow) begin
      lws_d = w_lw1;  nls_d = w_nl1;  hbs_d = w_hb1;  vbs_d = w_vb1;
      ptr_d = '0;
      line_d = '0;
    end

    // tx_rd_q always holds the word at ptr_q, captured whole in one cycle.
    if (w_ld) begin
      dat_d  = tx_rd_q[31:24];
      sh_d   = {tx_rd_q[23:0], 8'h00};
      bidx_d = 2'd1;
      ptr_d  = ptr_q + BUF_AW'(1);
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ack_q <= 1'b0;
      en_q <= 1'b0;  cont_q <= 1'b0;  done_q <= 1'b0;
      lw_q <= '0;  nl_q <= '0;  hb_q <= '0;  vb_q <= '0;
      lws_q <= '0;  nls_q <= '0;  hbs_q <= '0;  vbs_q <= '0;
      state_q <= S_IDLE;  cnt_q <= '0;  line_q <= '0;  ptr_q <= '0;
      sh_q <= 32'd0;  bidx_q <= 2'd0;
      phase_q <= 1'b0;  vs_q <= 1'b0;  hr_q <= 1'b0;  dat_q <= 8'd0;
    end else begin
      ack_q <= WBs_CYC_i & WBs_STB_i & ~ack_q;
      en_q <= en_d;  cont_q <= cont_d;  done_q <= done_d;
      lw_q <= lw_d;  nl_q <= nl_d;  hb_q <= hb_d;  vb_q <= vb_d;
      lws_q <= lws_d;  nls_q <= nls_d;  hbs_q <= hbs_d;  vbs_q <= vbs_d;
      state_q <= state_d;  cnt_q <= cnt_d;  line_q <= line_d;  ptr_q <= ptr_d;
      sh_q <= sh_d;  bidx_q <= bidx_d;
      phase_q <= phase_d;  vs_q <= vs_d;  hr_q <= hr_d;  dat_q <= dat_d;
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr && WBs_ADR_i[9] && WBs_BYTE_STB_i[i])
        mem_q[WBs_ADR_i[BUF_AW-1:0]][8*i +: 8] <= WBs_DAT_i[8*i +: 8];
    end
    host_rd_q <= mem_q[WBs_ADR_i[BUF_AW-1:0]];
    tx_rd_q   <= mem_q[ptr_q];
  end

  assign WBs_ACK_o    = ack_q;
  assign PCLKO        = phase_q;
  assign VSYNCO       = vs_q;
  assign HREFO        = hr_q;
  assign CAM_DAT_o    = dat_q;
  assign Frame_Done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dvp_frame_tx : directed self-checking bench for dvp_frame_tx          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dvp_frame_tx;

  localparam int MAXP = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  adr = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  bs = '0;
  logic [31:0] dw = '0;
  logic [31:0] WBs_DAT_o;
  logic        WBs_ACK_o, PCLKO, VSYNCO, HREFO, Frame_Done_o;
  logic [7:0]  CAM_DAT_o;

  int n_cmp = 0;
  int n_bad = 0;

  dvp_frame_tx dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(bs), .WBs_DAT_i(dw),
    .WBs_DAT_o(WBs_DAT_o), .WBs_ACK_o(WBs_ACK_o), .PCLKO(PCLKO),
    .VSYNCO(VSYNCO), .HREFO(HREFO), .CAM_DAT_o(CAM_DAT_o),
    .Frame_Done_o(Frame_Done_o)
  );

  always #5 clk = ~clk;

  // One log entry per PCLK period, taken while PCLKO is high.
  logic       vs_l [MAXP];
  logic       hr_l [MAXP];
  logic       dn_l [MAXP];
  logic [7:0] dt_l [MAXP];
  int n_per = 0;
  int hr_cnt = 0;

  always @(negedge clk) begin
    if (PCLKO) begin
      if (HREFO) hr_cnt++;
      if (n_per < MAXP) begin
        vs_l[n_per] = VSYNCO;
        hr_l[n_per] = HREFO;
        dn_l[n_per] = Frame_Done_o;
        dt_l[n_per] = CAM_DAT_o;
        n_per++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [9:0] a, input logic [3:0] be,
                    input logic [31:0] d, output logic [31:0] q);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; bs = be; dw = d;
    chk("ack_wait_state", WBs_ACK_o, 0);
    @(posedge clk); #1;
    chk("ack_asserted", WBs_ACK_o, 1);
    q = WBs_DAT_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_single", WBs_ACK_o, 0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    logic [31:0] unused_q;
    wb(1'b1, a, 4'hF, d, unused_q);
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] q);
    wb(1'b0, a, 4'hF, 32'd0, q);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !Frame_Done_o; i++) @(posedge clk);
    #1;
    chk("done_within_budget", Frame_Done_o, 1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  logic [7:0] bq[$];
  int a_vs, a_run0, a_gap0, a_dly, a_nz;

  task automatic analyze(input int b, input int e);
    int st, last_vs;
    bq.delete();
    a_vs = 0; a_run0 = 0; a_gap0 = 0; a_dly = -1; a_nz = 0; st = 0; last_vs = -1;
    for (int i = b; i < e; i++) begin
      if (vs_l[i]) begin a_vs++; last_vs = i; end
      if (hr_l[i]) bq.push_back(dt_l[i]);
      else if (dt_l[i] != 8'd0) a_nz++;
      case (st)
        0: if (hr_l[i]) begin st = 1; a_run0 = 1; end
        1: if (hr_l[i]) a_run0++; else begin st = 2; a_gap0 = 1; end
        2: if (!hr_l[i]) a_gap0++; else st = 3;
        default: ;
      endcase
    end
    for (int i = last_vs + 1; i < e; i++) begin
      if (dn_l[i]) begin a_dly = i - last_vs - 1; break; end
    end
  endtask

  logic [7:0] exp1 [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                            8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int b, h0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {PCLKO, VSYNCO, HREFO, Frame_Done_o, WBs_ACK_o, CAM_DAT_o}, 0);
    rd(10'h000, r); chk("reset_ctrl", r, 0);
    rd(10'h005, r); chk("reset_status", r, 0);

    // Register access, field widths and unmapped addresses
    wr(10'h001, 32'd2);          rd(10'h001, r); chk("rw_line_words", r, 32'd2);
    wr(10'h002, 32'hFFFF_FFFF);  rd(10'h002, r); chk("rw_num_lines_width", r, 32'h3FF);
    wr(10'h007, 32'hDEAD_BEEF);  rd(10'h007, r); chk("unmapped_reads_zero", r, 0);

    // Buffer access and byte lanes
    wr(10'h200, 32'h1122_3344);
    wr(10'h201, 32'h5566_7788);
    wr(10'h202, 32'h99AA_BBCC);
    wr(10'h203, 32'hDDEE_FF00);
    wr(10'h205, 32'h1122_3344);
    wb(1'b1, 10'h205, 4'b0100, 32'hAABB_CCDD, r);
    rd(10'h205, r); chk("byte_lane_0100", r, 32'h11BB_3344);
    rd(10'h202, r); chk("buffer_read", r, 32'h99AA_BBCC);

    // Single frame, with a LINE_WORDS write while busy
    wr(10'h001, 32'd2); wr(10'h002, 32'd2); wr(10'h003, 32'd3); wr(10'h004, 32'd2);
    b = n_per;
    wr(10'h000, 32'd5);
    rd(10'h005, r); chk("busy_during_frame", r[0], 1);
    wr(10'h001, 32'd5);
    wait_done(2000);
    analyze(b, n_per);
    chk("f1_vsync_periods", a_vs, 23);
    chk("f1_byte_count", bq.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("f1_byte%0d", i), bq[i], exp1[i]);
    chk("f1_href_run", a_run0, 8);
    chk("f1_hblank_gap", a_gap0, 3);
    chk("f1_done_delay", a_dly, 2);
    chk("f1_dat_zero_outside_href", a_nz, 0);
    rd(10'h005, r); chk("f1_status_done_idle", r[1:0], 2'b10);

    // W1C of DONE
    wr(10'h005, 32'd2);
    rd(10'h005, r); chk("w1c_status", r[1:0], 0);
    chk("w1c_frame_done_pin", Frame_Done_o, 0);

    // Zero-valued timing fields
    wr(10'h001, 32'd0); wr(10'h002, 32'd0); wr(10'h003, 32'd0); wr(10'h004, 32'd0);
    b = n_per;
    wr(10'h000, 32'd5);
    wait_done(1000);
    analyze(b, n_per);
    chk("zero_vsync_periods", a_vs, 6);
    chk("zero_byte_count", bq.size(), 4);
    chk("zero_bytes", {bq[0], bq[1], bq[2], bq[3]}, 32'h1122_3344);
    wr(10'h005, 32'd2);

    // Abort during line 1, then restart
    wr(10'h001, 32'd2); wr(10'h002, 32'd2); wr(10'h003, 32'd3); wr(10'h004, 32'd2);
    h0 = hr_cnt;
    wr(10'h000, 32'd5);
    for (int i = 0; i < 600 && (hr_cnt - h0) < 10; i++) @(posedge clk);
    chk("abort_reached_line1", ((hr_cnt - h0) >= 10) ? 32'd1 : 32'd0, 1);
    wr(10'h000, 32'd0);
    @(posedge clk); #1;
    chk("abort_pins_low", {PCLKO, VSYNCO, HREFO}, 0);
    chk("abort_no_done", Frame_Done_o, 0);
    rd(10'h005, r); chk("abort_status", r[1:0], 0);
    b = n_per;
    wr(10'h000, 32'd5);
    wait_done(2000);
    analyze(b, n_per);
    chk("restart_byte_count", bq.size(), 16);
    chk("restart_from_word0", {bq[0], bq[1], bq[2], bq[3]}, 32'h1122_3344);
    wr(10'h005, 32'd2);

    // Pointer wrap across the 256-word buffer
    wr(10'h001, 32'd200); wr(10'h003, 32'd1); wr(10'h004, 32'd1);
    b = n_per;
    wr(10'h000, 32'd5);
    wait_done(8000);
    analyze(b, n_per);
    chk("wrap_byte_count", bq.size(), 1600);
    chk("wrap_line1_word56", {bq[1024], bq[1025], bq[1026], bq[1027]}, 32'h1122_3344);
    wr(10'h005, 32'd2);

    // Reset while streaming continuously
    wr(10'h001, 32'd2); wr(10'h003, 32'd3); wr(10'h004, 32'd2);
    wr(10'h000, 32'd7);
    repeat (150) @(posedge clk);
    #1;
    chk("cont_done_seen", Frame_Done_o, 1);
    rd(10'h005, r); chk("cont_still_busy", r[0], 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mid_outputs", {PCLKO, VSYNCO, HREFO, Frame_Done_o, WBs_ACK_o, CAM_DAT_o}, 0);
    rd(10'h000, r); chk("rst_mid_ctrl", r, 0);
    rd(10'h005, r); chk("rst_mid_status", r, 0);
    rd(10'h001, r); chk("rst_mid_line_words", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
